microsequencer: RTL

- Parametrised micro-program sequencer for the multicycle datapath. It replaces the bare state-indexed control ROM plus its external next-state logic.
- Holds the micro-program counter (upc) and reads the control store. The microinstruction's 2-bit address-control field selects the next upc: fetch, dispatch-1, dispatch-2 or sequential.
- Drives every datapath control signal. Adds stall handling and illegal-opcode detection.

---
 rtl/microseq_pkg.sv | 108 ++++++++++
 rtl/microseq_dispatch.sv | 43 ++++
 rtl/microsequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/microseq_pkg.sv
// Shared definitions for the micro-program sequencer: address-control
// encoding, state numbers, opcodes, control-word bit positions and the
// default micro-program.
package microseq_pkg;

    typedef enum logic [1:0] {
        ADDR_FETCH = 2'b00,
        ADDR_DISP1 = 2'b01,
        ADDR_DISP2 = 2'b10,
        ADDR_SEQ   = 2'b11
    } addrctl_t;

    localparam int unsigned FETCH   = 0;
    localparam int unsigned DECODE  = 1;
    localparam int unsigned MEMADR  = 2;
    localparam int unsigned MEMRD   = 3;
    localparam int unsigned MEMWB   = 4;
    localparam int unsigned MEMWR   = 5;
    localparam int unsigned RTYPEEX = 6;
    localparam int unsigned RTYPEWB = 7;
    localparam int unsigned BEQEX   = 8;
    localparam int unsigned JEX     = 9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Bit positions inside the control word (addrctl excluded).
    localparam int BIT_PCWRITE     = 14;
    localparam int BIT_PCWRITECOND = 13;
    localparam int BIT_IORD        = 12;
    localparam int BIT_MEMWRITE    = 11;
    localparam int BIT_IRWRITE     = 10;
    localparam int BIT_MEMTOREG    = 9;
    localparam int BIT_PCSRC       = 7;
    localparam int BIT_ALUOP       = 5;
    localparam int BIT_ALUSRCB     = 3;
    localparam int BIT_ALUSRCA     = 2;
    localparam int BIT_REGWRITE    = 1;
    localparam int BIT_REGDST      = 0;

    localparam int DEF_CTRL_W = 15;

    // Default micro-program word {ctrl, addrctl}; unlisted addresses are
    // an all-zero word that returns to FETCH.
    function automatic logic [DEF_CTRL_W+1:0] default_word(input logic [31:0] addr);
        logic [DEF_CTRL_W-1:0] c;
        addrctl_t              a;
        c = '0;
        a = ADDR_FETCH;
        case (addr)
            FETCH: begin
                c[BIT_IRWRITE] = 1'b1;
                c[BIT_PCWRITE] = 1'b1;
                c[BIT_ALUSRCB +: 2] = 2'b01;
                a = ADDR_SEQ;
            end
            DECODE: begin
                c[BIT_ALUSRCB +: 2] = 2'b11;
                a = ADDR_DISP1;
            end
            MEMADR: begin
                c[BIT_ALUSRCA] = 1'b1;
                c[BIT_ALUSRCB +: 2] = 2'b10;
                a = ADDR_DISP2;
            end
            MEMRD: begin
                c[BIT_IORD] = 1'b1;
                a = ADDR_SEQ;
            end
            MEMWB: begin
                c[BIT_REGWRITE] = 1'b1;
                c[BIT_MEMTOREG] = 1'b1;
            end
            MEMWR: begin
                c[BIT_IORD] = 1'b1;
                c[BIT_MEMWRITE] = 1'b1;
            end
            RTYPEEX: begin
                c[BIT_ALUSRCA] = 1'b1;
                c[BIT_ALUOP +: 2] = 2'b10;
                a = ADDR_SEQ;
            end
            RTYPEWB: begin
                c[BIT_REGWRITE] = 1'b1;
                c[BIT_REGDST] = 1'b1;
            end
            BEQEX: begin
                c[BIT_ALUSRCA] = 1'b1;
                c[BIT_ALUOP +: 2] = 2'b01;
                c[BIT_PCWRITECOND] = 1'b1;
                c[BIT_PCSRC +: 2] = 2'b01;
            end
            JEX: begin
                c[BIT_PCWRITE] = 1'b1;
                c[BIT_PCSRC +: 2] = 2'b10;
            end
            default: begin
                c = '0;
                a = ADDR_FETCH;
            end
        endcase
        return {c, a};
    endfunction

endpackage

// File: rtl/microseq_dispatch.sv
// Opcode dispatch tables: dispatch-1 (from DECODE) and dispatch-2 (from
// MEMADR), each with a valid flag that is low for unknown opcodes.
module microseq_dispatch #(
    parameter int UPC_W = 4,
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [UPC_W-1:0] target1,
    output logic [UPC_W-1:0] target2,
    output logic             valid1,
    output logic             valid2
);
    import microseq_pkg::*;

    // Table lookup; unknown opcodes leave both valid flags low.
    always_comb begin
        target1 = '0;
        target2 = '0;
        valid1  = 1'b0;
        valid2  = 1'b0;
        if (opcode == OPC_W'(OP_RTYPE)) begin
            target1 = UPC_W'(RTYPEEX);
            valid1  = 1'b1;
        end else if (opcode == OPC_W'(OP_LW)) begin
            target1 = UPC_W'(MEMADR);
            target2 = UPC_W'(MEMRD);
            valid1  = 1'b1;
            valid2  = 1'b1;
        end else if (opcode == OPC_W'(OP_SW)) begin
            target1 = UPC_W'(MEMADR);
            target2 = UPC_W'(MEMWR);
            valid1  = 1'b1;
            valid2  = 1'b1;
        end else if (opcode == OPC_W'(OP_BEQ)) begin
            target1 = UPC_W'(BEQEX);
            valid1  = 1'b1;
        end else if (opcode == OPC_W'(OP_J)) begin
            target1 = UPC_W'(JEX);
            valid1  = 1'b1;
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Micro-program sequencer: holds upc, reads the control store, selects the
// next upc from the address-control field, handles stall and illegal opcodes.
// Optional writable control store when MICROSEQ_WCS_EN is defined.
// Stall semantics: stall=1 freezes upc/ucycles/illegal_op and zeroes ctrl
// in the same cycle; there is no other handshake on this block.
module microsequencer #(
    parameter int UPC_W  = 4,
    parameter int DEPTH  = 10,
    parameter int CTRL_W = 15,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              stall,
`ifdef MICROSEQ_WCS_EN
    input  logic              wcs_we,
    input  logic [UPC_W-1:0]  wcs_addr,
    input  logic [CTRL_W+1:0] wcs_data,
`endif
    output logic [CTRL_W-1:0] ctrl,
    output logic [UPC_W-1:0]  upc,
    output logic              illegal_op,
    output logic [31:0]       ucycles
);
    import microseq_pkg::*;

    localparam int WORD_W = CTRL_W + 2;
    localparam logic [UPC_W:0] DEPTH_L = (UPC_W+1)'(DEPTH);

    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] word;
    logic              in_range;
    addrctl_t          addrctl;
    logic [UPC_W-1:0]  upc_next;
    logic              illegal_next;
    logic [UPC_W-1:0]  target1;
    logic [UPC_W-1:0]  target2;
    logic              valid1;
    logic              valid2;

    assign in_range = ({1'b0, upc} < DEPTH_L);

`ifdef MICROSEQ_WCS_EN
    typedef logic [DEPTH-1:0][WORD_W-1:0] store_t;

    function automatic store_t init_store();
        store_t s;
        for (int i = 0; i < DEPTH; i++) begin
            s[i] = WORD_W'(default_word(32'(i)));
        end
        return s;
    endfunction

    // Contents survive reset; only the power-up image is the default program.
    store_t store_mem = init_store();

    // Synchronous write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wcs_we && ({1'b0, wcs_addr} < DEPTH_L)) begin
            store_mem[wcs_addr] <= wcs_data;
        end
    end

    assign cur_word = store_mem[upc];
`else
    assign cur_word = WORD_W'(default_word(32'(upc)));
`endif

    // Addresses beyond the store behave as an all-zero return-to-FETCH word.
    assign word    = in_range ? cur_word : '0;
    assign addrctl = addrctl_t'(word[1:0]);

    microseq_dispatch #(
        .UPC_W (UPC_W),
        .OPC_W (OPC_W)
    ) u_dispatch (
        .opcode  (opcode),
        .target1 (target1),
        .target2 (target2),
        .valid1  (valid1),
        .valid2  (valid2)
    );

    // State register plus cycle counter; everything freezes under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc        <= '0;
            illegal_op <= 1'b0;
            ucycles    <= '0;
        end else if (!stall) begin
            upc        <= upc_next;
            illegal_op <= illegal_next;
            ucycles    <= ucycles + 32'd1;
        end
    end

    // Next-state selection from the address-control field.
    always_comb begin
        upc_next     = '0;
        illegal_next = 1'b0;
        case (addrctl)
            ADDR_FETCH: upc_next = '0;
            ADDR_DISP1: begin
                if (valid1) upc_next = target1;
                else        illegal_next = 1'b1;
            end
            ADDR_DISP2: begin
                if (valid2) upc_next = target2;
                else        illegal_next = 1'b1;
            end
            ADDR_SEQ:   upc_next = upc + UPC_W'(1);
            default:    upc_next = '0;
        endcase
    end

    // Control outputs: blanked while stalled so nothing commits.
    always_comb begin
        ctrl = '0;
        if (!stall) ctrl = word[WORD_W-1:2];
    end

endmodule
